decode_exec_latch: RTL and testbench

Parametrised successor to the ID/EX pipeline register; it sits between decode and execute. It adds a valid/ready handshake, a 2-entry skid buffer so that upstream ready is registered, and a synchronous flush for branch mispredicts. It also carries a saturating stall counter for performance monitoring. Field widths are parameters so the same block serves the wider-register and 5-bit-rd variants.

---
 rtl/decode_exec_latch.sv | 140 ++++++++++++++
 tb/tb_decode_exec_latch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_exec_latch.sv
// ID/EX pipeline register between decode and execute: valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush and a saturating stall counter.
module decode_exec_latch #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4,
  parameter int SIG_W  = 11,
  parameter int COND_W = 4,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              clr_cnt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] next_pc,
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB,
  input  logic [DATA_W-1:0] br_se,
  input  logic [DATA_W-1:0] ls_se,
  input  logic [DATA_W-1:0] alu_se,
  input  logic [RD_W-1:0]   rd,
  input  logic [SIG_W-1:0]  signals,
  input  logic [COND_W-1:0] instr_cond,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] dataA_out,
  output logic [DATA_W-1:0] dataB_out,
  output logic [DATA_W-1:0] br_se_out,
  output logic [DATA_W-1:0] ls_se_out,
  output logic [DATA_W-1:0] alu_se_out,
  output logic [RD_W-1:0]   rd_out,
  output logic [SIG_W-1:0]  sign_out,
  output logic [COND_W-1:0] br_cond,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PW = 6*DATA_W + RD_W + SIG_W + COND_W;

  // State encoding is {M_v, S_v}, so the valid bits fall straight out of the register.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic             m_v, s_v;
  logic             accept, fire;
  logic             load_m_in, load_m_s, load_s;
  logic [PW-1:0]    in_bus, m_q, s_q;
  logic [SIG_W-1:0] m_sig;

  assign in_bus    = {next_pc, dataA, dataB, br_se, ls_se, alu_se, rd, signals, instr_cond};
  assign m_v       = state[1];
  assign s_v       = state[0];
  assign out_valid = m_v;
  assign in_ready  = (SKID != 0) ? ~s_v : (~m_v | out_ready);
  assign accept    = in_valid & in_ready;
  assign fire      = m_v & out_ready;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_m_in = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (fire && accept) begin
          load_m_in = 1'b1;
        end else if (fire) begin
          state_nxt = EMPTY;
        end else if (accept && (SKID != 0)) begin
          load_s    = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (fire) begin
          load_m_s  = 1'b1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // A mispredict kills everything held, including a beat accepted this cycle.
    if (flush) begin
      state_nxt = EMPTY;
      load_m_in = 1'b0;
      load_m_s  = 1'b0;
      load_s    = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // NOTE: the two payload entries are plain registers, not a RAM, so they take the async
  // reset and the outputs are defined straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (load_m_in)     m_q <= in_bus;
      else if (load_m_s) m_q <= s_q;
      if (load_s)        s_q <= in_bus;
    end
  end

  assign {pc_out, dataA_out, dataB_out, br_se_out, ls_se_out, alu_se_out,
          rd_out, m_sig, br_cond} = m_q;
  // Execute sees a NOP during bubbles; the rest of the payload just holds.
  assign sign_out = m_v ? m_sig : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (m_v && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_exec_latch.sv
// Directed bench for decode_exec_latch: default build, a CNT_W=4 build and a SKID=0 build
// share one stimulus stream; each scenario checks the build it targets.
module tb_decode_exec_latch;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        flush = 1'b0, clr_cnt = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] next_pc = '0, dataA = '0, dataB = '0, br_se = '0, ls_se = '0, alu_se = '0;
  logic [3:0]  rd = '0, instr_cond = '0;
  logic [10:0] signals = '0;

  logic        in_ready, out_valid;
  logic [31:0] pc_out, dataA_out, dataB_out, br_se_out, ls_se_out, alu_se_out;
  logic [3:0]  rd_out, br_cond;
  logic [10:0] sign_out;
  logic [15:0] stall_cnt;

  logic        in_ready_s, out_valid_s;
  logic [31:0] pc_out_s, dataA_out_s, dataB_out_s, br_se_out_s, ls_se_out_s, alu_se_out_s;
  logic [3:0]  rd_out_s, br_cond_s;
  logic [10:0] sign_out_s;
  logic [3:0]  stall_cnt_s;

  logic        in_ready_n, out_valid_n;
  logic [31:0] pc_out_n, dataA_out_n, dataB_out_n, br_se_out_n, ls_se_out_n, alu_se_out_n;
  logic [3:0]  rd_out_n, br_cond_n;
  logic [10:0] sign_out_n;
  logic [15:0] stall_cnt_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_exec_latch dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(in_ready),
    .next_pc(next_pc), .dataA(dataA), .dataB(dataB), .br_se(br_se), .ls_se(ls_se),
    .alu_se(alu_se), .rd(rd), .signals(signals), .instr_cond(instr_cond),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .dataA_out(dataA_out), .dataB_out(dataB_out), .br_se_out(br_se_out),
    .ls_se_out(ls_se_out), .alu_se_out(alu_se_out), .rd_out(rd_out), .sign_out(sign_out),
    .br_cond(br_cond), .stall_cnt(stall_cnt)
  );

  decode_exec_latch #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .next_pc(next_pc), .dataA(dataA), .dataB(dataB), .br_se(br_se), .ls_se(ls_se),
    .alu_se(alu_se), .rd(rd), .signals(signals), .instr_cond(instr_cond),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .pc_out(pc_out_s), .dataA_out(dataA_out_s), .dataB_out(dataB_out_s),
    .br_se_out(br_se_out_s), .ls_se_out(ls_se_out_s), .alu_se_out(alu_se_out_s),
    .rd_out(rd_out_s), .sign_out(sign_out_s), .br_cond(br_cond_s), .stall_cnt(stall_cnt_s)
  );

  decode_exec_latch #(.SKID(0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(in_ready_n),
    .next_pc(next_pc), .dataA(dataA), .dataB(dataB), .br_se(br_se), .ls_se(ls_se),
    .alu_se(alu_se), .rd(rd), .signals(signals), .instr_cond(instr_cond),
    .out_valid(out_valid_n), .out_ready(out_ready),
    .pc_out(pc_out_n), .dataA_out(dataA_out_n), .dataB_out(dataB_out_n),
    .br_se_out(br_se_out_n), .ls_se_out(ls_se_out_n), .alu_se_out(alu_se_out_n),
    .rd_out(rd_out_n), .sign_out(sign_out_n), .br_cond(br_cond_n), .stall_cnt(stall_cnt_n)
  );

  typedef struct {
    logic        fl, clr, iv;
    logic [31:0] pc;
    logic        rdy;
    logic        eir, eov;
    logic [31:0] epc;
    int          est;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic fl, clr, iv, input logic [31:0] pc, input logic rdy,
                              input logic eir, eov, input logic [31:0] epc, input int est);
    vec_t v;
    v.fl = fl; v.clr = clr; v.iv = iv; v.pc = pc; v.rdy = rdy;
    v.eir = eir; v.eov = eov; v.epc = epc; v.est = est;
    return v;
  endfunction

  // Every payload field is a distinct function of pc, so one pc identifies the whole beat.
  function automatic logic [199:0] payload_of(input logic [31:0] pc);
    return {pc, ~pc, pc + 32'd1, pc << 1, pc ^ 32'h5a5a_5a5a, {pc[15:0], pc[31:16]},
            pc[7:4], ~pc[5:2]};
  endfunction

  task automatic drive(input logic iv, input logic [31:0] pc, input logic rdy,
                       input logic fl, input logic clr);
    in_valid   = iv;
    next_pc    = pc;
    dataA      = ~pc;
    dataB      = pc + 32'd1;
    br_se      = pc << 1;
    ls_se      = pc ^ 32'h5a5a_5a5a;
    alu_se     = {pc[15:0], pc[31:16]};
    rd         = pc[7:4];
    signals    = pc[10:0];
    instr_cond = ~pc[5:2];
    out_ready  = rdy;
    flush      = fl;
    clr_cnt    = clr;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 1, 32'h100, 1,  1, 1, 32'h100, 0);
    vecs[1]  = mk(0, 0, 1, 32'h104, 1,  1, 1, 32'h104, 0);
    vecs[2]  = mk(0, 0, 1, 32'h108, 1,  1, 1, 32'h108, 0);
    vecs[3]  = mk(0, 0, 0, 32'h0,   1,  1, 0, 32'h108, 0);
    vecs[4]  = mk(0, 0, 1, 32'hA0,  0,  1, 1, 32'hA0,  0);
    vecs[5]  = mk(0, 0, 1, 32'hA4,  0,  0, 1, 32'hA0,  1);
    vecs[6]  = mk(0, 0, 1, 32'hA8,  0,  0, 1, 32'hA0,  2);
    vecs[7]  = mk(0, 0, 1, 32'hA8,  0,  0, 1, 32'hA0,  3);
    vecs[8]  = mk(0, 0, 1, 32'hA8,  1,  1, 1, 32'hA4,  3);
    vecs[9]  = mk(0, 0, 1, 32'hA8,  1,  1, 1, 32'hA8,  3);
    vecs[10] = mk(0, 0, 0, 32'h0,   1,  1, 0, 32'hA8,  3);
    vecs[11] = mk(0, 0, 1, 32'hB0,  0,  1, 1, 32'hB0,  3);
    vecs[12] = mk(0, 0, 1, 32'hB4,  0,  0, 1, 32'hB0,  4);
    vecs[13] = mk(1, 0, 1, 32'hC0,  0,  1, 0, 32'hB0,  5);
    vecs[14] = mk(0, 0, 1, 32'hC4,  0,  1, 1, 32'hC4,  5);
    vecs[15] = mk(0, 0, 0, 32'h0,   1,  1, 0, 32'hC4,  5);
    vecs[16] = mk(0, 0, 1, 32'hD0,  0,  1, 1, 32'hD0,  5);
    vecs[17] = mk(1, 0, 1, 32'hD4,  1,  1, 0, 32'hD0,  5);
    vecs[18] = mk(0, 0, 0, 32'h0,   1,  1, 0, 32'hD0,  5);
    vecs[19] = mk(0, 1, 0, 32'h0,   0,  1, 0, 32'hD0,  0);

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset sign_out", sign_out, 0);
    check("reset stall_cnt", stall_cnt, 0);
    check("reset payload", {pc_out, dataA_out, dataB_out, br_se_out, ls_se_out, alu_se_out,
                            rd_out, br_cond}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming, backpressure, flush and counter clear on the default build
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].iv, vecs[i].pc, vecs[i].rdy, vecs[i].fl, vecs[i].clr);
      @(negedge clk);
      check($sformatf("row%0d in_ready", i), in_ready, vecs[i].eir);
      check($sformatf("row%0d out_valid", i), out_valid, vecs[i].eov);
      check($sformatf("row%0d sign_out", i), sign_out, vecs[i].eov ? vecs[i].epc[10:0] : 11'd0);
      check($sformatf("row%0d payload", i),
            {pc_out, dataA_out, dataB_out, br_se_out, ls_se_out, alu_se_out, rd_out, br_cond},
            payload_of(vecs[i].epc));
      check($sformatf("row%0d stall_cnt", i), stall_cnt, vecs[i].est);
    end

    // Asynchronous reset mid-stream while FULL
    drive(1, 32'h200, 0, 0, 0);
    @(negedge clk);
    drive(1, 32'h204, 0, 0, 0);
    @(negedge clk);
    check("pre-reset full in_ready", in_ready, 0);
    check("pre-reset stall_cnt", stall_cnt, 1);
    drive(0, 32'h0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", out_valid, 0);
    check("midreset in_ready", in_ready, 1);
    check("midreset stall_cnt", stall_cnt, 0);
    check("midreset sign_out", sign_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stall counter saturation on the CNT_W=4 build, then clear against a stall
    drive(1, 32'h300, 0, 0, 0);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 0);
    repeat (20) @(negedge clk);
    check("sat stall_cnt 4-bit", stall_cnt_s, 15);
    check("sat stall_cnt 16-bit", stall_cnt, 20);
    check("sat payload", {pc_out_s, dataA_out_s, dataB_out_s, br_se_out_s, ls_se_out_s,
                          alu_se_out_s, rd_out_s, br_cond_s}, payload_of(32'h300));
    check("sat sign_out", sign_out_s, 11'h300);
    check("sat in_ready", {in_ready_s, out_valid_s}, 2'b11);
    drive(0, 32'h0, 0, 0, 1);
    @(negedge clk);
    check("clr over stall 4-bit", stall_cnt_s, 0);
    check("clr over stall 16-bit", stall_cnt, 0);
    drive(0, 32'h0, 0, 0, 0);
    @(negedge clk);
    check("count resumes after clr", stall_cnt_s, 1);

    // SKID=0 build: combinational in_ready and replace-on-fire
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h400, 0, 0, 0);
    #1 check("ns empty in_ready", in_ready_n, 1);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 0);
    #1;
    check("ns full stalled in_ready", in_ready_n, 0);
    check("ns out_valid", out_valid_n, 1);
    check("ns pc_out", pc_out_n, 32'h400);
    drive(1, 32'h404, 1, 0, 0);
    #1 check("ns full firing in_ready", in_ready_n, 1);
    @(negedge clk);
    check("ns replaced payload", {pc_out_n, dataA_out_n, dataB_out_n, br_se_out_n, ls_se_out_n,
                                  alu_se_out_n, rd_out_n, br_cond_n}, payload_of(32'h404));
    check("ns replaced sign_out", sign_out_n, 11'h404);
    check("ns stall_cnt", stall_cnt_n, 0);
    drive(1, 32'h408, 0, 0, 0);
    #1 check("ns blocked in_ready", in_ready_n, 0);
    @(negedge clk);
    check("ns held pc_out", pc_out_n, 32'h404);
    check("ns stalled count", stall_cnt_n, 1);
    drive(0, 32'h0, 1, 0, 0);
    @(negedge clk);
    check("ns drained out_valid", out_valid_n, 0);
    check("ns drained sign_out", sign_out_n, 0);
    check("ns drained in_ready", in_ready_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
